// File: rtl/trg_pls_pkg.sv
// trg_pls_pkg: shared constants and channel state type for the multi-channel trigger pulser
package trg_pls_pkg;
    localparam logic [6:0] A_CTRL     = 7'h00;
    localparam logic [6:0] A_ENABLE   = 7'h01;
    localparam logic [6:0] A_CH_BASE  = 7'h10;
    localparam logic [1:0] OFF_DELAY  = 2'd0;
    localparam logic [1:0] OFF_WIDTH  = 2'd1;
    localparam logic [1:0] OFF_PERIOD = 2'd2;
    localparam int         HDR_W      = 8;

    function automatic int frame_len(input int cnt_w);
        return HDR_W + cnt_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_PULSE,
        ST_GAP
    } ch_state_e;
endpackage

// File: rtl/trg_pls_chan.sv
// trg_pls_chan: one trigger channel sequencer (IDLE -> DELAY -> PULSE -> IDLE | GAP)
// Ports: clk_50/reset (sync, active high); fire/abort one-cycle commands;
//        en channel enable; delay/width/period live register values (latched on fire);
//        pulse trigger output; busy high whenever not IDLE.
// Build option: TRG_PLS_REPEAT_EN adds the period input and GAP state for repeating pulses.
module trg_pls_chan
    import trg_pls_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             fire,
    input  logic             abort,
    input  logic             en,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
`ifdef TRG_PLS_REPEAT_EN
    input  logic [CNT_W-1:0] period,
`endif
    output logic             pulse,
    output logic             busy
);
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dly_sh_q, dly_sh_d;
    logic [CNT_W-1:0] wid_sh_q, wid_sh_d;
`ifdef TRG_PLS_REPEAT_EN
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
`endif
    logic             last;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dly_sh_q <= '0;
            wid_sh_q <= '0;
`ifdef TRG_PLS_REPEAT_EN
            per_sh_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dly_sh_q <= dly_sh_d;
            wid_sh_q <= wid_sh_d;
`ifdef TRG_PLS_REPEAT_EN
            per_sh_q <= per_sh_d;
`endif
        end
    end

    // Each timed state loads its length into cnt and leaves when cnt reaches 1;
    // zero-length phases are skipped so pulse timing stays exact for DELAY=0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dly_sh_d = dly_sh_q;
        wid_sh_d = wid_sh_q;
`ifdef TRG_PLS_REPEAT_EN
        per_sh_d = per_sh_q;
`endif
        last     = cnt_q == CNT_W'(1);
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (fire && en) begin
                    dly_sh_d = delay;
                    wid_sh_d = width;
`ifdef TRG_PLS_REPEAT_EN
                    per_sh_d = period;
`endif
                    state_d  = delay != '0 ? ST_DELAY : width != '0 ? ST_PULSE : ST_IDLE;
                    cnt_d    = delay != '0 ? delay : width;
                end
                ST_DELAY: begin
                    state_d = !last ? ST_DELAY : wid_sh_q != '0 ? ST_PULSE : ST_IDLE;
                    cnt_d   = last ? wid_sh_q : cnt_q - 1'b1;
                end
                ST_PULSE: begin
`ifdef TRG_PLS_REPEAT_EN
                    state_d = !last ? ST_PULSE : (per_sh_q != '0 && en) ? ST_GAP : ST_IDLE;
                    cnt_d   = last ? per_sh_q : cnt_q - 1'b1;
`else
                    state_d = last ? ST_IDLE : ST_PULSE;
                    cnt_d   = cnt_q - 1'b1;
`endif
                end
`ifdef TRG_PLS_REPEAT_EN
                ST_GAP: begin
                    state_d = !en ? ST_IDLE : !last ? ST_GAP : dly_sh_q != '0 ? ST_DELAY : ST_PULSE;
                    cnt_d   = !last ? cnt_q - 1'b1 : dly_sh_q != '0 ? dly_sh_q : wid_sh_q;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pulse = state_q == ST_PULSE;
        busy  = state_q != ST_IDLE;
    end
endmodule

// File: rtl/trg_pls_multi.sv
// trg_pls_multi: SPI-programmed multi-channel trigger pulse generator
// Ports: clk_50 system clock; reset sync active high; spi_clk/spi_cs/spi_mosi async
//        SPI mode 0 slave inputs (frame: reserved bit, 7-bit address, CNT_W-bit data, MSB first);
//        trg_pulse/trg_busy per-channel outputs; frame_err one-cycle strobe on a discarded frame.
// Build option: TRG_PLS_REPEAT_EN enables PERIOD registers and repeating pulse trains.
module trg_pls_multi
    import trg_pls_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic [NUM_CH-1:0] trg_pulse,
    output logic [NUM_CH-1:0] trg_busy,
    output logic              frame_err
);
    localparam int FRAME_W = frame_len(CNT_W);
    localparam int SH_W    = FRAME_W - 1;
    localparam int BC_W    = $clog2(FRAME_W + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(FRAME_W);
    localparam logic [BC_W-1:0] BC_OVER = BC_W'(FRAME_W + 1);

    // [0],[1] form the synchronizer, [2] is the previous synced value for edge detection
    logic [2:0]       sclk_q, sclk_d;
    logic [2:0]       cs_q, cs_d;
    logic [1:0]       mosi_q, mosi_d;
    // The reserved top bit is shifted out and never stored
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [BC_W-1:0]  bc_q, bc_d;
    logic             frame_err_q, frame_err_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [CNT_W-1:0] dly_q [NUM_CH], dly_d [NUM_CH];
    logic [CNT_W-1:0] wid_q [NUM_CH], wid_d [NUM_CH];
`ifdef TRG_PLS_REPEAT_EN
    logic [CNT_W-1:0] per_q [NUM_CH], per_d [NUM_CH];
`endif
    logic             sclk_rise, cs_rise, commit, ctrl, fire, abort, ch_ok;
    logic [6:0]       addr, ch_off;
    logic [CNT_W-1:0] data;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            sclk_q      <= '0;
            cs_q        <= '1;
            mosi_q      <= '0;
            sh_q        <= '0;
            bc_q        <= '0;
            frame_err_q <= 1'b0;
            en_q        <= '0;
            dly_q       <= '{default: '0};
            wid_q       <= '{default: '0};
`ifdef TRG_PLS_REPEAT_EN
            per_q       <= '{default: '0};
`endif
        end else begin
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            sh_q        <= sh_d;
            bc_q        <= bc_d;
            frame_err_q <= frame_err_d;
            en_q        <= en_d;
            dly_q       <= dly_d;
            wid_q       <= wid_d;
`ifdef TRG_PLS_REPEAT_EN
            per_q       <= per_d;
`endif
        end
    end

    // Bit count saturates one past a full frame so over-long frames are still rejected
    always_comb begin
        sclk_d      = {sclk_q[1:0], spi_clk};
        cs_d        = {cs_q[1:0], spi_cs};
        mosi_d      = {mosi_q[0], spi_mosi};
        sclk_rise   = sclk_q[1] && !sclk_q[2];
        cs_rise     = cs_q[1] && !cs_q[2];
        sh_d        = (sclk_rise && !cs_q[1]) ? {sh_q[SH_W-2:0], mosi_q[1]} : sh_q;
        bc_d        = cs_q[1] ? '0 : (sclk_rise && bc_q != BC_OVER) ? bc_q + 1'b1 : bc_q;
        commit      = cs_rise && bc_q == BC_FULL;
        frame_err_d = cs_rise && bc_q != BC_FULL;
    end

    always_comb begin
        addr   = sh_q[SH_W-1 -: 7];
        data   = sh_q[CNT_W-1:0];
        ch_off = addr - A_CH_BASE;
        ch_ok  = commit && addr >= A_CH_BASE && ch_off[6:2] < 5'(NUM_CH);
        ctrl   = commit && addr == A_CTRL;
        abort  = ctrl && data[1];
        fire   = ctrl && data[0] && !data[1];
        en_d   = (commit && addr == A_ENABLE) ? data[NUM_CH-1:0] : en_q;
        for (int i = 0; i < NUM_CH; i++) begin
            dly_d[i] = (ch_ok && ch_off[6:2] == 5'(i) && ch_off[1:0] == OFF_DELAY) ? data : dly_q[i];
            wid_d[i] = (ch_ok && ch_off[6:2] == 5'(i) && ch_off[1:0] == OFF_WIDTH) ? data : wid_q[i];
`ifdef TRG_PLS_REPEAT_EN
            per_d[i] = (ch_ok && ch_off[6:2] == 5'(i) && ch_off[1:0] == OFF_PERIOD) ? data : per_q[i];
`endif
        end
    end

    assign frame_err = frame_err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        trg_pls_chan #(.CNT_W(CNT_W)) u_chan (
            .clk_50 (clk_50),
            .reset  (reset),
            .fire   (fire),
            .abort  (abort),
            .en     (en_q[c]),
            .delay  (dly_q[c]),
            .width  (wid_q[c]),
`ifdef TRG_PLS_REPEAT_EN
            .period (per_q[c]),
`endif
            .pulse  (trg_pulse[c]),
            .busy   (trg_busy[c])
        );
    end
endmodule

// File: doc/trg_pls_multi.md
TRG_PLS_MULTI -- requirements
Module: trg_pls_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of trigger channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of delay/width/period counters and SPI data field.
REQ-003 SHALL have port clk_50  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spi_clk  input  1  SPI serial clock, asynchronous to clk_50, mode 0.
REQ-006 SHALL have port spi_cs  input  1  SPI chip select, active low, asynchronous.
REQ-007 SHALL have port spi_mosi  input  1  SPI data in, MSB first, asynchronous.
REQ-008 SHALL have port trg_pulse  output  NUM_CH  per-channel trigger pulse, active high.
REQ-009 SHALL have port trg_busy  output  NUM_CH  per-channel high while channel not IDLE.
REQ-010 SHALL have port frame_err  output  1  one-cycle strobe on a discarded SPI frame.

Function
REQ-011 SHALL pass spi_clk, spi_cs, spi_mosi through 2-FF synchronizers; shift on detected synced spi_clk rising edge while synced spi_cs low.
REQ-012 SHALL treat a frame as 8+CNT_W bits: bit[top] reserved, next 7 bits address, low CNT_W bits data.
REQ-013 SHALL commit a frame on synced spi_cs rising edge only if exactly 8+CNT_W bits shifted; otherwise discard and pulse frame_err for 1 cycle.
REQ-014 SHALL decode address 0x00 CTRL: data[0] FIRE, data[1] ABORT; both self-clearing, not stored.
REQ-015 SHALL decode address 0x01 ENABLE: data[NUM_CH-1:0] channel enable mask.
REQ-016 SHALL decode per-channel registers at 0x10+4*ch: +0 DELAY, +1 WIDTH, +2 PERIOD (macro only); unmapped addresses ignored.
REQ-017 SHALL run per-channel FSM IDLE -> DELAY -> PULSE -> (IDLE | GAP).
REQ-018 SHALL, on FIRE committed in cycle T, move each enabled IDLE channel to DELAY at T+1 and latch DELAY/WIDTH/PERIOD into shadow registers.
REQ-019 SHALL drive trg_pulse[ch] high from cycle T+1+DELAY for exactly WIDTH cycles, then leave PULSE.
REQ-020 SHALL, with WIDTH=0, produce no pulse and return IDLE at T+1+DELAY.
REQ-021 SHALL ignore FIRE for channels not IDLE or not enabled.
REQ-022 SHALL, on ABORT, force all channels IDLE and trg_pulse low on the next cycle; ABORT and FIRE in one frame: ABORT wins.
REQ-023 SHALL apply register writes during an active sequence only at the next FIRE (shadow copy).
REQ-024 SHALL saturate nothing: counters are CNT_W bits, DELAY/WIDTH/PERIOD up to 2^CNT_W-1 cycles.
REQ-025 SHALL drive trg_busy[ch] high in every state except IDLE.

Reset
REQ-026 SHALL, on reset, clear all registers, shift state, FSMs to IDLE, trg_pulse=0, trg_busy=0, frame_err=0.
REQ-027 SHALL abort any in-progress SPI frame and pulse on reset; a frame straddling reset release is discarded with frame_err.

Configuration
REQ-028 SHALL, with TRG_PLS_REPEAT_EN defined, implement PERIOD registers and GAP state: after PULSE, if PERIOD>0 wait PERIOD cycles in GAP then re-enter DELAY with same shadow values until ABORT or ENABLE bit cleared.
REQ-029 SHALL, without TRG_PLS_REPEAT_EN, omit PERIOD registers and GAP; PULSE always returns IDLE; writes to +2 ignored.

Structure
REQ-030 SHALL place address constants, frame length constant, and FSM state enum in package trg_pls_pkg.
REQ-031 SHALL implement one channel FSM as sub-module trg_pls_chan, instantiated NUM_CH times via generate.
REQ-032 SHALL keep SPI synchronizer, shifter and register file in trg_pls_multi.

Verification
REQ-033 SHALL test: DELAY0=10, WIDTH0=3, ENABLE=0x01, FIRE at T -> trg_pulse[0] high T+11..T+13, others low.
REQ-034 SHALL test: 23-bit frame (CNT_W=16) -> frame_err 1 cycle, no register change.
REQ-035 SHALL test: ch1 WIDTH=0, FIRE -> trg_busy[1] high cycles T+1..T+DELAY, trg_pulse[1] never high.
REQ-036 SHALL test: ch0 DELAY=100, WIDTH=50, ABORT at T+120 -> trg_pulse[0] low at T+121, trg_busy=0.
REQ-037 SHALL test: second FIRE while ch0 in PULSE -> no restart; write DELAY0=5 mid-pulse -> used only on next FIRE.
REQ-038 SHALL test (TRG_PLS_REPEAT_EN): DELAY=2, WIDTH=4, PERIOD=10 -> pulses repeat every 16 cycles until ENABLE=0.
